// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU, 34-cycle latency.
// Optional DIV_BYPASS_EN: divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic            is_rem;
  logic            qsign;
  logic            rsign;
  logic            spec;
  logic [XLEN-1:0] spec_val;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   rem;
  logic [4:0]      cnt;

  logic            in_signed, a_neg, b_neg, div0, ovf, spec_in;
  logic [XLEN-1:0] a_mag, b_mag, spec_in_val;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] trial;
  logic [XLEN-1:0] q_fix, r_fix, fix_val;

  // Operand decode for the request being offered in IDLE.
  always_comb begin
    in_signed   = ~op[0];
    a_neg       = in_signed & dividend[XLEN-1];
    b_neg       = in_signed & divisor[XLEN-1];
    a_mag       = a_neg ? -dividend : dividend;
    b_mag       = b_neg ? -divisor : divisor;
    div0        = (divisor == '0);
    ovf         = in_signed && (dividend == MIN_NEG) && (divisor == '1);
    spec_in     = div0 | ovf;
    if (div0)
      spec_in_val = op[1] ? dividend : '1;
    else
      spec_in_val = op[1] ? '0 : MIN_NEG;
  end

  // One restoring step: a borrow out of the trial subtraction means "keep".
  always_comb begin
    shifted = {rem[XLEN-1:0], quo[XLEN-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs};
    q_fix   = qsign ? -quo : quo;
    r_fix   = rsign ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    if (spec)
      fix_val = spec_val;
    else
      fix_val = is_rem ? r_fix : q_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cnt      <= '0;
      is_rem   <= 1'b0;
      qsign    <= 1'b0;
      rsign    <= 1'b0;
      spec     <= 1'b0;
      spec_val <= '0;
      quo      <= '0;
      dvs      <= '0;
      rem      <= '0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              is_rem   <= op[1];
              qsign    <= a_neg ^ b_neg;
              rsign    <= a_neg;
              spec     <= spec_in;
              spec_val <= spec_in_val;
              quo      <= a_mag;
              dvs      <= b_mag;
              rem      <= '0;
              cnt      <= 5'd31;
`ifdef DIV_BYPASS_EN
              if (spec_in) begin
                result <= spec_in_val;
                done   <= 1'b1;
                busy   <= 1'b1;
                state  <= DONE;
              end else begin
                busy  <= 1'b1;
                state <= CALC;
              end
`else
              busy  <= 1'b1;
              state <= CALC;
`endif
            end
          end
          CALC: begin
            if (!trial[XLEN+1]) begin
              rem <= trial[XLEN:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= shifted;
              quo <= {quo[XLEN-2:0], 1'b0};
            end
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0)
              state <= FIX;
          end
          FIX: begin
            result <= fix_val;
            done   <= 1'b1;
            state  <= DONE;
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed-vector bench for div_unit with an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .kill(kill), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected-behaviour state, owned by the stimulus and consumed by the compare process.
  bit          chk_en = 1'b0;
  bit          pend = 1'b0;
  int          due = -1;
  int          bstart = -1;
  int          bend = -2;
  int          rst_at = -10;
  logic [31:0] pval = '0;
  logic [31:0] exp_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    case (o)
      2'd0: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      2'd1: return a / b;
      2'd2: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_BYPASS_EN
    if (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return 34;
  endfunction

  // Per-cycle compare of busy/done/result against the model's timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_done, exp_busy;
      exp_done = pend && (cyc == due);
      if (exp_done) exp_res = pval;
      if (cyc == rst_at + 1) exp_res = '0;
      exp_busy = (cyc >= bstart) && (cyc <= bend);
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("done", {31'd0, done}, {31'd0, exp_done});
      check("result", result, exp_res);
      if (pend && cyc >= due) pend = 1'b0;
    end
  end

  // Issues one request in the current (negedge-aligned) cycle; optionally waits for completion.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input bit wait_done);
    int lat;
    check("model", model(o, a, b), lit);
    lat = latency(o, a, b);
    op = o; dividend = a; divisor = b; start = 1'b1;
    pval = lit; due = cyc + lat; bstart = cyc + 1; bend = cyc + lat; pend = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); dividend = $urandom; divisor = $urandom;
    if (wait_done) begin
      repeat (lat) @(negedge clk);
      check("held_result", result, lit);
    end
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    chk_en = 1'b1;
    @(negedge clk);

    run_op(2'd1, 32'd100, 32'd7, 32'd14, 1'b1);
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 1'b1);
    run_op(2'd0, -32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b1);
    run_op(2'd2, -32'sd100, 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(2'd2, 32'd100, -32'sd7, 32'd2, 1'b1);
    run_op(2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op(2'd3, 32'd5, 32'd0, 32'd5, 1'b1);
    run_op(2'd2, -32'sd7, 32'd0, 32'hFFFF_FFF9, 1'b1);
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    run_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    run_op(2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1);
    run_op(2'd0, 32'd7, -32'sd2, 32'hFFFF_FFFD, 1'b1);
    run_op(2'd2, 32'd7, -32'sd2, 32'd1, 1'b1);

    // Kill at T+10, restart at T+11, expect done at T+45.
    t0 = cyc;
    run_op(2'd1, 32'd1000, 32'd3, 32'd333, 1'b0);
    while (cyc < t0 + 10) @(negedge clk);
    kill = 1'b1; pend = 1'b0; bend = cyc;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    run_op(2'd3, 32'd1000, 32'd3, 32'd1, 1'b0);
    repeat (33) @(negedge clk);
    check("restart_done_t45", {31'd0, done}, 32'd1);
    check("restart_cycle", 32'(cyc - t0), 32'd45);
    @(negedge clk);

    // Starts during CALC and during DONE must be ignored.
    t0 = cyc;
    run_op(2'd1, 32'd81, 32'd9, 32'd9, 1'b0);
    while (cyc < t0 + 5) @(negedge clk);
    op = 2'd1; dividend = 32'd1; divisor = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 34) @(negedge clk);
    op = 2'd0; dividend = 32'd9; divisor = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("ignored_start_result", result, 32'd9);

    // Reset at T+20 discards the operation.
    t0 = cyc;
    run_op(2'd1, 32'd50, 32'd5, 32'd10, 1'b0);
    while (cyc < t0 + 20) @(negedge clk);
    rst = 1'b1; pend = 1'b0; bend = cyc; rst_at = cyc;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_result", result, 32'd0);
    repeat (40) @(negedge clk);
    run_op(2'd0, 32'd42, 32'd6, 32'd7, 1'b1);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
